// File: rtl/proc_datapath_if.sv
// Control-word and observation bundle between the instruction controller and proc_datapath.
// Latency: none of its own. Every signal is a plain wire.
// Backpressure: none. The controller drives a new control word every cycle.
//
// master (controller side): drives D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
//                           RF_Ra_addr, RF_Rb_addr, ALU_s0; observes results.
// slave  (datapath side)  : consumes the control word; drives ALU_Q, Ra_data,
//                           Rb_data, Mem_Q, zero.
interface proc_datapath_if #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
);
  // control word
  logic [DM_AW-1:0]  D_addr;
  logic              D_wr;
  logic              RF_s;
  logic [RF_AW-1:0]  RF_W_addr;
  logic              RF_W_en;
  logic [RF_AW-1:0]  RF_Ra_addr;
  logic [RF_AW-1:0]  RF_Rb_addr;
  logic [2:0]        ALU_s0;
  // observation
  logic [DATA_W-1:0] ALU_Q;
  logic [DATA_W-1:0] Ra_data;
  logic [DATA_W-1:0] Rb_data;
  logic [DATA_W-1:0] Mem_Q;
  logic              zero;

  modport master (
    output D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0,
    input  ALU_Q, Ra_data, Rb_data, Mem_Q, zero
  );

  modport slave (
    input  D_addr, D_wr, RF_s, RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0,
    output ALU_Q, Ra_data, Rb_data, Mem_Q, zero
  );
endinterface

// File: rtl/proc_datapath.sv
// Processor datapath: 16x16 register file, 256x16 data memory, RF write mux, 16-bit ALU.
// Latency: RF reads and the ALU are combinational. Mem_Q lags D_addr by one clock. Writes land on posedge.
// Backpressure: none. The controller's control word is obeyed every cycle.
//
// Ports:
//   clk   - system clock, all state updates on posedge
//   reset - asynchronous active-high; clears the RF and Mem_Q but not the memory array
//   dp    - proc_datapath_if.slave: control word in, ALU_Q/Ra_data/Rb_data/Mem_Q/zero out
module proc_datapath #(
  parameter int DATA_W = 16,
  parameter int RF_AW  = 4,
  parameter int DM_AW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  proc_datapath_if.slave   dp
);

  localparam int RF_N = 1 << RF_AW;
  localparam int DM_N = 1 << DM_AW;

  // ALU operation codes
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_NOT  = 3'd6;
  localparam logic [2:0] ALU_INC  = 3'd7;

  logic [DATA_W-1:0] r_rf  [RF_N];
  logic [DATA_W-1:0] r_mem [DM_N];
  logic [DATA_W-1:0] r_mem_q;

  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_rb;
  logic [DATA_W-1:0] w_alu;
  logic [DATA_W-1:0] w_wdata;

  // Combinational read ports with no write bypass. A register being written
  // shows its old value until the edge.
  assign w_ra = r_rf[dp.RF_Ra_addr];
  assign w_rb = r_rf[dp.RF_Rb_addr];

  // All arithmetic wraps mod 2^DATA_W. There is no carry out.
  always_comb begin
    w_alu = '0;
    case (dp.ALU_s0)
      ALU_PASS: w_alu = w_ra;
      ALU_ADD:  w_alu = w_ra + w_rb;
      ALU_SUB:  w_alu = w_ra - w_rb;
      ALU_AND:  w_alu = w_ra & w_rb;
      ALU_OR:   w_alu = w_ra | w_rb;
      ALU_XOR:  w_alu = w_ra ^ w_rb;
      ALU_NOT:  w_alu = ~w_ra;
      ALU_INC:  w_alu = w_ra + DATA_W'(1);
      default:  w_alu = '0;
    endcase
  end

  // The LOAD path writes back the registered memory word, so the controller
  // holds D_addr for two cycles and raises RF_s/RF_W_en in the second one.
  assign w_wdata = dp.RF_s ? r_mem_q : w_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RF_N; i++) begin
        r_rf[i] <= '0;
      end
    end else if (dp.RF_W_en) begin
      r_rf[dp.RF_W_addr] <= w_wdata;
    end
  end

  // Registered read. Same-address read and write in one cycle is read-first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_q <= '0;
    end else begin
      r_mem_q <= r_mem[dp.D_addr];
    end
  end

  // The array keeps its contents through reset. A write is suppressed only
  // while reset is high at the edge.
  always_ff @(posedge clk) begin
    if (!reset && dp.D_wr) begin
      r_mem[dp.D_addr] <= w_ra;
    end
  end

  assign dp.ALU_Q   = w_alu;
  assign dp.Ra_data = w_ra;
  assign dp.Rb_data = w_rb;
  assign dp.Mem_Q   = r_mem_q;
  assign dp.zero    = (w_alu == '0);

endmodule

// File: tb/tb_proc_datapath.sv
// Directed bench for proc_datapath: hand-computed vectors for reset, ALU ops,
// RF write-back, STORE/LOAD, read-first behaviour and asynchronous reset.
module tb_proc_datapath;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  proc_datapath_if #(.DATA_W(16), .RF_AW(4), .DM_AW(8)) dp_if ();

  proc_datapath #(.DATA_W(16), .RF_AW(4), .DM_AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .dp    (dp_if)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Read a register through port A. Callers keep RF_W_en low.
  task automatic rd(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dp_if.RF_Ra_addr = a;
    #1;
    chk(tag, dp_if.Ra_data, exp);
  endtask

  initial begin
    reset            = 1'b1;
    dp_if.D_addr     = '0;
    dp_if.D_wr       = 1'b0;
    dp_if.RF_s       = 1'b0;
    dp_if.RF_W_addr  = '0;
    dp_if.RF_W_en    = 1'b0;
    dp_if.RF_Ra_addr = '0;
    dp_if.RF_Rb_addr = '0;
    dp_if.ALU_s0     = 3'd0;
    repeat (2) tick();

    // reset state
    chk("rst_ra",   dp_if.Ra_data, 16'h0000);
    chk("rst_rb",   dp_if.Rb_data, 16'h0000);
    chk("rst_alu",  dp_if.ALU_Q,   16'h0000);
    chk("rst_zero", 16'(dp_if.zero), 16'h0001);
    chk("rst_memq", dp_if.Mem_Q,   16'h0000);
    reset = 1'b0;

    // increment chain into R1: 1, 2, 3
    dp_if.ALU_s0 = 3'd7; dp_if.RF_Ra_addr = 4'd0; dp_if.RF_W_addr = 4'd1; dp_if.RF_W_en = 1'b1;
    #1 chk("inc0_alu", dp_if.ALU_Q, 16'h0001);
    tick();
    dp_if.RF_Ra_addr = 4'd1;
    #1 chk("inc1_alu", dp_if.ALU_Q, 16'h0002);
    tick();
    tick();
    dp_if.RF_W_en = 1'b0;
    rd("r1_is_3", 4'd1, 16'h0003);

    // R5 = 1, R2 = R3 = ~R0
    dp_if.ALU_s0 = 3'd7; dp_if.RF_Ra_addr = 4'd0; dp_if.RF_W_addr = 4'd5; dp_if.RF_W_en = 1'b1;
    tick();
    dp_if.ALU_s0 = 3'd6; dp_if.RF_W_addr = 4'd2;
    #1 chk("not_alu", dp_if.ALU_Q, 16'hFFFF);
    tick();
    dp_if.RF_W_addr = 4'd3;
    tick();
    dp_if.RF_W_en = 1'b0;
    rd("r2_ffff", 4'd2, 16'hFFFF);
    rd("r5_one",  4'd5, 16'h0001);

    // add wrap: R3 = 0xFFFF + 1 = 0
    dp_if.ALU_s0 = 3'd1; dp_if.RF_Ra_addr = 4'd2; dp_if.RF_Rb_addr = 4'd5;
    dp_if.RF_W_addr = 4'd3; dp_if.RF_W_en = 1'b1;
    #1 chk("add_alu",  dp_if.ALU_Q, 16'h0000);
    chk("add_zero", 16'(dp_if.zero), 16'h0001);
    tick();
    dp_if.RF_W_en = 1'b0;
    rd("r3_zero", 4'd3, 16'h0000);

    // subtract wrap: R4 = 3 - 0xFFFF = 4
    tick();
    dp_if.ALU_s0 = 3'd2; dp_if.RF_Ra_addr = 4'd1; dp_if.RF_Rb_addr = 4'd2;
    dp_if.RF_W_addr = 4'd4; dp_if.RF_W_en = 1'b1;
    #1 chk("sub_alu", dp_if.ALU_Q, 16'h0004);
    tick();
    dp_if.RF_W_en = 1'b0;
    rd("r4_four", 4'd4, 16'h0004);

    // logic ops, A=R1=3, B=R4=4
    tick();
    dp_if.RF_Ra_addr = 4'd1; dp_if.RF_Rb_addr = 4'd4; dp_if.ALU_s0 = 3'd3;
    #1 chk("and_alu", dp_if.ALU_Q, 16'h0000);
    chk("and_zero", 16'(dp_if.zero), 16'h0001);
    dp_if.ALU_s0 = 3'd4;
    #1 chk("or_alu", dp_if.ALU_Q, 16'h0007);
    chk("or_zero", 16'(dp_if.zero), 16'h0000);
    dp_if.ALU_s0 = 3'd5; dp_if.RF_Ra_addr = 4'd2; dp_if.RF_Rb_addr = 4'd1;
    #1 chk("xor_alu", dp_if.ALU_Q, 16'hFFFC);
    dp_if.ALU_s0 = 3'd0; dp_if.RF_Ra_addr = 4'd4;
    #1 chk("pass_alu", dp_if.ALU_Q, 16'h0004);

    // STORE R1 to mem[41], then LOAD it into R7
    tick();
    dp_if.RF_Ra_addr = 4'd1; dp_if.D_addr = 8'd41; dp_if.D_wr = 1'b1;
    tick();
    dp_if.D_wr = 1'b0;
    tick();
    chk("load_memq", dp_if.Mem_Q, 16'h0003);
    dp_if.RF_s = 1'b1; dp_if.RF_W_addr = 4'd7; dp_if.RF_W_en = 1'b1;
    tick();
    dp_if.RF_W_en = 1'b0; dp_if.RF_s = 1'b0;
    rd("r7_load", 4'd7, 16'h0003);

    // read-first memory: mem[10]=3, then write 4 while reading 10
    dp_if.RF_Ra_addr = 4'd1; dp_if.D_addr = 8'd10; dp_if.D_wr = 1'b1;
    tick();
    dp_if.RF_Ra_addr = 4'd4;
    tick();
    chk("mem_rdfirst_old", dp_if.Mem_Q, 16'h0003);
    dp_if.D_wr = 1'b0;
    tick();
    chk("mem_rdfirst_new", dp_if.Mem_Q, 16'h0004);

    // read-first RF: R3 = R3 + 1 while reading R3
    dp_if.ALU_s0 = 3'd7; dp_if.RF_Ra_addr = 4'd3; dp_if.RF_W_addr = 4'd3; dp_if.RF_W_en = 1'b1;
    #1 chk("rf_old_ra", dp_if.Ra_data, 16'h0000);
    chk("rf_old_alu", dp_if.ALU_Q, 16'h0001);
    tick();
    dp_if.RF_W_en = 1'b0;
    chk("rf_new_ra", dp_if.Ra_data, 16'h0001);
    chk("rf_new_alu", dp_if.ALU_Q, 16'h0002);

    // async reset between edges with both write enables high
    tick();
    dp_if.D_addr = 8'd10; dp_if.D_wr = 1'b1; dp_if.RF_Ra_addr = 4'd1; dp_if.RF_Rb_addr = 4'd4;
    dp_if.ALU_s0 = 3'd7; dp_if.RF_W_addr = 4'd1; dp_if.RF_W_en = 1'b1;
    #1 chk("pre_rst_alu", dp_if.ALU_Q, 16'h0004);
    #1 reset = 1'b1;
    #1 chk("arst_ra", dp_if.Ra_data, 16'h0000);
    chk("arst_rb",   dp_if.Rb_data, 16'h0000);
    chk("arst_memq", dp_if.Mem_Q,   16'h0000);
    chk("arst_alu",  dp_if.ALU_Q,   16'h0001);
    tick();
    dp_if.D_wr = 1'b0; dp_if.RF_W_en = 1'b0;
    reset = 1'b0;
    #1 chk("post_rst_r1", dp_if.Ra_data, 16'h0000);
    rd("post_rst_r4", 4'd4, 16'h0000);
    tick();
    chk("mem_kept", dp_if.Mem_Q, 16'h0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
